// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: shared encodings and constants for the rhythm-game hit judge.
// Optional feature macro: HIT_JUDGE_MISTAP_EN (mistap counting/combo break).
package hit_judge_pkg;

  // Number of note lanes / player keys.
  localparam int LANES = 4;

  // Judge FSM encoding, exported on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Points per hit lane by grade.
  localparam logic [3:0] WEIGHT_PERFECT = 4'd2;
  localparam logic [3:0] WEIGHT_GOOD    = 4'd1;

  // Saturation ceilings.
  localparam logic [15:0] SAT16_MAX = 16'hFFFF;
  localparam logic [7:0]  COMBO_MAX = 8'd255;

  // Count of set bits in a lane vector (0..LANES).
  function automatic logic [2:0] lane_count(input logic [LANES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// hit_judge_if: game-side signals of the hit judge bundled into one port.
// The mistap_cnt member exists only when HIT_JUDGE_MISTAP_EN is defined.
interface hit_judge_if;

  logic                              game_active;
  logic                              row_tick;
  logic [hit_judge_pkg::LANES-1:0]   judge_row;
  logic [hit_judge_pkg::LANES-1:0]   key;
  logic [hit_judge_pkg::LANES-1:0]   hit_mask;
  logic [hit_judge_pkg::LANES-1:0]   miss_mask;
  logic                              grade_perfect;
  logic [15:0]                       score;
  logic [7:0]                        combo;
  logic [7:0]                        max_combo;
  logic [1:0]                        state;
`ifdef HIT_JUDGE_MISTAP_EN
  logic [15:0]                       mistap_cnt;
`endif

  // Game controller / stimulus side.
  modport master (
    output game_active, row_tick, judge_row, key,
    input  hit_mask, miss_mask, grade_perfect, score, combo, max_combo, state
`ifdef HIT_JUDGE_MISTAP_EN
    , input mistap_cnt
`endif
  );

  // Judge side.
  modport slave (
    input  game_active, row_tick, judge_row, key,
    output hit_mask, miss_mask, grade_perfect, score, combo, max_combo, state
`ifdef HIT_JUDGE_MISTAP_EN
    , output mistap_cnt
`endif
  );

endinterface

// File: rtl/hit_judge_key_edge_detect.sv
// key_edge_detect: per-lane two-flop synchroniser for raw player keys followed
// by a rising-edge detector. The pulse is valid in the cycle after the second
// synchroniser flop first samples high, so the judging register captures it
// on the third clock edge after the raw key change.
module key_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_rise
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Synchronise the raw key and keep the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        prev_reg  <= 1'b0;
      end else begin
        sync1_reg <= key_raw[gi];
        sync2_reg <= sync1_reg;
        prev_reg  <= sync2_reg;
      end
    end

    assign key_rise[gi] = sync2_reg & ~prev_reg;
  end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: judges player key presses against the bottom row of the note
// matrix, grading hits PERFECT/GOOD by intra-tick phase, flagging misses at
// each row tick and maintaining score, combo and max_combo.
// Optional feature macro: HIT_JUDGE_MISTAP_EN -- a key press on a lane with no
// pending note breaks the combo and is counted in mistap_cnt.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int PHASE_W     = 16,
  parameter int PERFECT_WIN = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  hit_judge_if.slave  bus
);

  // Phase is compared in 32 bits so any PHASE_W up to 32 works.
  localparam logic [31:0] WIN32 = 32'(PERFECT_WIN);

  state_t               state_reg, state_next;
  logic [PHASE_W-1:0]   phase_reg, phase_next;
  logic [LANES-1:0]     pending_reg, pending_next;
  logic [LANES-1:0]     hit_mask_reg, hit_mask_next;
  logic [LANES-1:0]     miss_mask_reg, miss_mask_next;
  logic                 grade_reg, grade_next;
  logic [15:0]          score_reg, score_next;
  logic [7:0]           combo_reg, combo_next;
  logic [7:0]           max_combo_reg, max_combo_next;

  logic [LANES-1:0]     key_edge;
  logic                 judging;
  logic                 start_song;
  logic                 stop_song;

  logic [LANES-1:0]     hits;
  logic [LANES-1:0]     misses;
  logic [LANES-1:0]     pend_after;
  logic                 grade_now;
  logic [2:0]           hit_n;
  logic [3:0]           score_add;
  logic [16:0]          score_sum;
  logic [8:0]           combo_sum;
  logic [7:0]           combo_hit;
  logic                 combo_break;

`ifdef HIT_JUDGE_MISTAP_EN
  logic [LANES-1:0]     mistaps;
  logic [2:0]           mistap_n;
  logic [16:0]          mistap_sum;
  logic [15:0]          mistap_cnt_reg, mistap_cnt_next;
`endif

  key_edge_detect #(
    .WIDTH (LANES)
  ) u_key_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (bus.key),
    .key_rise (key_edge)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state plus the song start/stop/judging strobes.
  always_comb begin
    state_next = state_reg;
    start_song = 1'b0;
    stop_song  = 1'b0;
    judging    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.game_active) begin
          state_next = ST_RUN;
          start_song = 1'b1;
        end
      end
      ST_RUN: begin
        // The cycle game_active drops is not judged, so no misses fire.
        if (!bus.game_active) begin
          state_next = ST_DONE;
          stop_song  = 1'b1;
        end else begin
          judging = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.game_active) begin
          state_next = ST_RUN;
          start_song = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef HIT_JUDGE_MISTAP_EN
  assign mistaps    = key_edge & ~pending_reg & {LANES{judging}};
  assign mistap_n   = lane_count(mistaps);
  assign mistap_sum = {1'b0, mistap_cnt_reg} + 17'(mistap_n);
`endif

  // Judge this cycle's key edges: hits, misses, shared grade, score/combo sums.
  always_comb begin
    hits  = key_edge & pending_reg & {LANES{judging}};
    hit_n = lane_count(hits);
    if (bus.row_tick) begin
      // Edges coinciding with a tick still count against the old row, as GOOD.
      grade_now  = 1'b0;
      misses     = pending_reg & ~hits & {LANES{judging}};
      pend_after = bus.judge_row;
    end else begin
      grade_now  = (32'(phase_reg) < WIN32);
      misses     = '0;
      pend_after = pending_reg & ~hits;
    end
    score_add   = 4'(hit_n) * (grade_now ? WEIGHT_PERFECT : WEIGHT_GOOD);
    score_sum   = {1'b0, score_reg} + 17'(score_add);
    combo_sum   = {1'b0, combo_reg} + 9'(hit_n);
    combo_hit   = (combo_sum > {1'b0, COMBO_MAX}) ? COMBO_MAX : combo_sum[7:0];
    combo_break = |misses;
`ifdef HIT_JUDGE_MISTAP_EN
    combo_break = combo_break | (|mistaps);
`endif
  end

  // Next values for pending row, phase, result pulses and counters.
  always_comb begin
    phase_next     = phase_reg;
    pending_next   = pending_reg;
    hit_mask_next  = '0;
    miss_mask_next = '0;
    grade_next     = 1'b0;
    score_next     = score_reg;
    combo_next     = combo_reg;
    max_combo_next = max_combo_reg;
`ifdef HIT_JUDGE_MISTAP_EN
    mistap_cnt_next = mistap_cnt_reg;
`endif
    if (start_song) begin
      phase_next     = '0;
      pending_next   = '0;
      score_next     = '0;
      combo_next     = '0;
      max_combo_next = '0;
`ifdef HIT_JUDGE_MISTAP_EN
      mistap_cnt_next = '0;
`endif
    end else if (judging) begin
      hit_mask_next  = hits;
      miss_mask_next = misses;
      grade_next     = grade_now & (|hits);
      pending_next   = pend_after;
      if (bus.row_tick) begin
        phase_next = '0;
      end else if (phase_reg != '1) begin
        phase_next = phase_reg + PHASE_W'(1);
      end
      score_next     = score_sum[16] ? SAT16_MAX : score_sum[15:0];
      // max_combo sees the combo including this cycle's hits, before any break.
      max_combo_next = (combo_hit > max_combo_reg) ? combo_hit : max_combo_reg;
      combo_next     = combo_break ? 8'd0 : combo_hit;
`ifdef HIT_JUDGE_MISTAP_EN
      mistap_cnt_next = mistap_sum[16] ? SAT16_MAX : mistap_sum[15:0];
`endif
    end else if (stop_song) begin
      pending_next = '0;
    end
  end

  // Judge datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg     <= '0;
      pending_reg   <= '0;
      hit_mask_reg  <= '0;
      miss_mask_reg <= '0;
      grade_reg     <= 1'b0;
      score_reg     <= '0;
      combo_reg     <= '0;
      max_combo_reg <= '0;
`ifdef HIT_JUDGE_MISTAP_EN
      mistap_cnt_reg <= '0;
`endif
    end else begin
      phase_reg     <= phase_next;
      pending_reg   <= pending_next;
      hit_mask_reg  <= hit_mask_next;
      miss_mask_reg <= miss_mask_next;
      grade_reg     <= grade_next;
      score_reg     <= score_next;
      combo_reg     <= combo_next;
      max_combo_reg <= max_combo_next;
`ifdef HIT_JUDGE_MISTAP_EN
      mistap_cnt_reg <= mistap_cnt_next;
`endif
    end
  end

  assign bus.hit_mask      = hit_mask_reg;
  assign bus.miss_mask     = miss_mask_reg;
  assign bus.grade_perfect = grade_reg;
  assign bus.score         = score_reg;
  assign bus.combo         = combo_reg;
  assign bus.max_combo     = max_combo_reg;
  assign bus.state         = state_reg;
`ifdef HIT_JUDGE_MISTAP_EN
  assign bus.mistap_cnt    = mistap_cnt_reg;
`endif

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed self-checking bench for hit_judge.
// Also builds with HIT_JUDGE_MISTAP_EN defined (checks mistap behaviour).
module tb_hit_judge;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hit_judge_if bus ();

  hit_judge #(
    .PHASE_W     (16),
    .PERFECT_WIN (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle row tick loading row; returns 1 ns after the tick edge.
  task automatic tick(input logic [3:0] row);
    bus.row_tick  = 1'b1;
    bus.judge_row = row;
    clk_n(1);
    bus.row_tick  = 1'b0;
  endtask

  // Called right after tick(): raw press so the edge is judged at phase k;
  // returns 1 ns after the judging edge (results visible).
  task automatic tap(input logic [3:0] lanes, input int k);
    clk_n(k - 2);
    bus.key = lanes;
    clk_n(3);
  endtask

  task automatic restart();
    bus.game_active = 1'b0;
    clk_n(1);
    bus.game_active = 1'b1;
    clk_n(1);
  endtask

  initial begin
    bus.game_active = 1'b0;
    bus.row_tick    = 1'b0;
    bus.judge_row   = 4'b0000;
    bus.key         = 4'b0000;

    // Reset state.
    clk_n(3);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_combo", 32'(bus.combo), 32'd0);
    check("rst_max", 32'(bus.max_combo), 32'd0);
    check("rst_hit", 32'(bus.hit_mask), 32'd0);
    check("rst_miss", 32'(bus.miss_mask), 32'd0);
    check("rst_grade", 32'(bus.grade_perfect), 32'd0);
    rst_n = 1'b1;
    clk_n(2);

    // Song start.
    bus.game_active = 1'b1;
    clk_n(1);
    check("start_state", 32'(bus.state), 32'd1);

    // PERFECT hit on lane 0 at phase 10.
    tick(4'b0001);
    tap(4'b0001, 10);
    check("perf_hit", 32'(bus.hit_mask), 32'h1);
    check("perf_grade", 32'(bus.grade_perfect), 32'd1);
    check("perf_score", 32'(bus.score), 32'd2);
    check("perf_combo", 32'(bus.combo), 32'd1);
    bus.key = 4'b0000;

    // Late GOOD hit on lane 2 at phase 1500.
    tick(4'b0100);
    tap(4'b0100, 1500);
    check("late_hit", 32'(bus.hit_mask), 32'h4);
    check("late_grade", 32'(bus.grade_perfect), 32'd0);
    check("late_score", 32'(bus.score), 32'd3);
    check("late_combo", 32'(bus.combo), 32'd2);
    bus.key = 4'b0000;

    // Three PERFECT lanes in one cycle: +6, combo 5.
    tick(4'b0111);
    tap(4'b0111, 10);
    check("multi_hit", 32'(bus.hit_mask), 32'h7);
    check("multi_score", 32'(bus.score), 32'd9);
    check("multi_combo", 32'(bus.combo), 32'd5);
    check("multi_max", 32'(bus.max_combo), 32'd5);
    bus.key = 4'b0000;

    // Unplayed row 1010 misses at the next tick.
    tick(4'b1010);
    clk_n(20);
    tick(4'b0000);
    check("miss_mask", 32'(bus.miss_mask), 32'hA);
    check("miss_hit", 32'(bus.hit_mask), 32'h0);
    check("miss_combo", 32'(bus.combo), 32'd0);
    check("miss_max", 32'(bus.max_combo), 32'd5);
    check("miss_score", 32'(bus.score), 32'd9);

    // Key edge on lane 1 judged in the same cycle as a tick, old pending 0011.
    tick(4'b0011);
    clk_n(5);
    bus.key = 4'b0010;
    clk_n(2);
    tick(4'b0000);
    check("coll_hit", 32'(bus.hit_mask), 32'h2);
    check("coll_grade", 32'(bus.grade_perfect), 32'd0);
    check("coll_miss", 32'(bus.miss_mask), 32'h1);
    check("coll_score", 32'(bus.score), 32'd10);
    check("coll_combo", 32'(bus.combo), 32'd0);
    check("coll_max", 32'(bus.max_combo), 32'd5);
    bus.key = 4'b0000;

    // game_active falls with notes pending and a tick: DONE, no misses.
    tick(4'b1111);
    clk_n(3);
    bus.game_active = 1'b0;
    bus.row_tick    = 1'b1;
    clk_n(1);
    bus.row_tick    = 1'b0;
    check("done_state", 32'(bus.state), 32'd2);
    check("done_miss", 32'(bus.miss_mask), 32'h0);
    check("done_score", 32'(bus.score), 32'd10);
    tick(4'b1111);
    clk_n(4);
    check("done_hold_score", 32'(bus.score), 32'd10);
    check("done_hold_max", 32'(bus.max_combo), 32'd5);

    // Restart clears counters and pending.
    bus.game_active = 1'b1;
    clk_n(1);
    check("re_state", 32'(bus.state), 32'd1);
    check("re_score", 32'(bus.score), 32'd0);
    check("re_combo", 32'(bus.combo), 32'd0);
    check("re_max", 32'(bus.max_combo), 32'd0);
    tick(4'b0000);
    check("re_nomiss", 32'(bus.miss_mask), 32'h0);

    // Tap on an empty lane after building combo 1.
    tick(4'b0001);
    tap(4'b0001, 10);
    check("pre_tap_combo", 32'(bus.combo), 32'd1);
    bus.key = 4'b0000;
    clk_n(2);
    bus.key = 4'b1000;
    clk_n(3);
    check("tap_hit", 32'(bus.hit_mask), 32'h0);
    check("tap_score", 32'(bus.score), 32'd2);
    check("tap_max", 32'(bus.max_combo), 32'd1);
`ifdef HIT_JUDGE_MISTAP_EN
    check("tap_combo", 32'(bus.combo), 32'd0);
    check("tap_cnt", 32'(bus.mistap_cnt), 32'd1);
`else
    check("tap_combo", 32'(bus.combo), 32'd1);
`endif
    bus.key = 4'b0000;

    // Saturation: 8191 rounds of four PERFECT lanes (+8 each).
    restart();
    for (int r = 1; r <= 8191; r++) begin
      tick(4'b1111);
      tap(4'b1111, 3);
      bus.key = 4'b0000;
      if (r == 1) begin
        check("sat_r1_score", 32'(bus.score), 32'd8);
        check("sat_r1_combo", 32'(bus.combo), 32'd4);
      end
      if (r == 64) begin
        check("sat_r64_score", 32'(bus.score), 32'd512);
        check("sat_r64_combo", 32'(bus.combo), 32'd255);
      end
    end
    tick(4'b0111);
    tap(4'b0111, 3);
    bus.key = 4'b0000;
    check("sat_fffe", 32'(bus.score), 32'hFFFE);
    check("sat_combo", 32'(bus.combo), 32'd255);
    check("sat_max", 32'(bus.max_combo), 32'd255);
    tick(4'b0011);
    tap(4'b0011, 3);
    bus.key = 4'b0000;
    check("sat_hit", 32'(bus.hit_mask), 32'h3);
    check("sat_grade", 32'(bus.grade_perfect), 32'd1);
    check("sat_ffff", 32'(bus.score), 32'hFFFF);
    check("sat_combo255", 32'(bus.combo), 32'd255);

    // Asynchronous reset mid-song with pending notes.
    tick(4'b1111);
    rst_n = 1'b0;
    #2;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_score", 32'(bus.score), 32'd0);
    check("arst_max", 32'(bus.max_combo), 32'd0);
    #2;
    rst_n = 1'b1;
    clk_n(1);
    check("arst_run", 32'(bus.state), 32'd1);
    tick(4'b0000);
    check("arst_nomiss", 32'(bus.miss_mask), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter PHASE_W, default 16: width of the intra-tick phase counter.
REQ-002 Parameter PERFECT_WIN, default 1000: phase values below this grade PERFECT, all others GOOD.
REQ-003 clk  input  1  game clock.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 game_active  input  1  level; high while a song is playing.
REQ-006 row_tick  input  1  one-clk strobe marking each note-matrix shift.
REQ-007 judge_row  input  4  bottom row (row 15) of the note matrix, one bit per lane.
REQ-008 key  input  4  raw player keys, one per lane, asynchronous to clk.
REQ-009 hit_mask  output  4  lanes hit this cycle (1-clk pulse).
REQ-010 miss_mask  output  4  lanes missed this cycle (1-clk pulse).
REQ-011 grade_perfect  output  1  qualifies hit_mask: 1 = PERFECT, 0 = GOOD.
REQ-012 score  output  16  accumulated score.
REQ-013 combo  output  8  current combo.
REQ-014 max_combo  output  8  highest combo this song.
REQ-015 state  output  2  FSM state (IDLE=0, RUN=1, DONE=2).

Function
REQ-016 Each key bit is synchronised through two flops, then rising-edge detected; a press becomes visible to judging 3 clk after the raw edge.
REQ-017 FSM: IDLE->RUN on game_active=1 (clears score, combo, max_combo, pending); RUN->DONE on game_active=0 (clears pending, holds score/combo/max_combo); DONE->RUN on game_active=1 with the same clears as IDLE->RUN.
REQ-018 In RUN, the phase counter resets to 0 on row_tick, otherwise increments, and saturates at all-ones.
REQ-019 In RUN on row_tick: pending[3:0] <= judge_row.
REQ-020 In RUN on a non-tick cycle, a key edge on lane L with pending[L]=1 sets hit_mask[L] and clears pending[L]; grade_perfect = (phase < PERFECT_WIN).
REQ-021 A key edge on a lane with pending=0 is otherwise ignored (see REQ-033).
REQ-022 On a row_tick cycle, key edges are first judged against the old pending with GOOD grade; lanes still pending after that set miss_mask; pending is then reloaded per REQ-019.
REQ-023 All hits in one cycle share a single grade; multiple lanes may hit and miss in the same cycle.
REQ-024 Score increments by 2 per PERFECT lane and 1 per GOOD lane, summed across lanes in the cycle, saturating at 16'hFFFF.
REQ-025 Combo adds the number of hit lanes, saturating at 255; if any miss occurs in the same cycle, combo becomes 0 after max_combo is updated.
REQ-026 max_combo <= max(max_combo, combo after the hits are added), evaluated every cycle in RUN.
REQ-027 In IDLE and DONE: hit_mask=0, miss_mask=0, and no score or combo change.
REQ-028 hit_mask, miss_mask and grade_perfect are registered; all counter updates become visible one clk after the judging cycle.

Reset
REQ-029 Asynchronous assertion; state=IDLE and every output, pending bit, phase counter and sync flop = 0.
REQ-030 Reset mid-song discards pending notes and generates no miss pulses.
REQ-031 Deassertion is synchronised externally; the first active edge after release evaluates normally.

Configuration
REQ-032 Macro HIT_JUDGE_MISTAP_EN controls mistap handling.
REQ-033 With HIT_JUDGE_MISTAP_EN defined, a key edge on a non-pending lane in RUN zeroes combo (after the max_combo update), and a 16-bit saturating output mistap_cnt counts such lanes.
REQ-034 Without HIT_JUDGE_MISTAP_EN, the mistap_cnt port does not exist and mistaps have no effect.

Structure
REQ-035 Package hit_judge_pkg holds the state encodings, the grade weights (2/1), the combo and score saturation constants, and the lane count 4.
REQ-036 Sub-module key_edge_detect (per-lane 2-flop synchroniser plus rising-edge pulse) is instantiated once, 4 bits wide.

Verification
REQ-037 Song start: judge_row=4'b0001 at tick, key[0] pressed so the edge arrives at phase 10 -> hit_mask=0001, grade_perfect=1, score=2, combo=1.
REQ-038 Late hit: press lane 2 at phase 1500 -> hit_mask=0100, grade_perfect=0, score +1.
REQ-039 Miss: judge_row=4'b1010 with no keys, next tick -> miss_mask=1010; combo 5->0; max_combo stays 5.
REQ-040 Tick collision: key edge on lane 1 in the same cycle as a tick, old pending=0011 -> hit_mask=0010 (GOOD), miss_mask=0001, combo=0.
REQ-041 Saturation: preload score=16'hFFFE and hit two PERFECT lanes -> score=16'hFFFF; with combo=255, a further hit leaves combo=255.
REQ-042 game_active falls mid-song -> DONE, score held, no miss pulses; game_active rises -> score=0, combo=0, max_combo=0. With HIT_JUDGE_MISTAP_EN defined, a tap on an empty lane -> combo=0, mistap_cnt=1.
